// File: rtl/uart_pkg.sv
// Shared types, defaults and helper functions for the uart block.
package uart_pkg;

  // Common state encoding for the TX and RX frame FSMs
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_BAUD_RATE  = 115200;
  localparam int unsigned DEF_CLK_FREQ   = 50000000;

  // Clock cycles per serial bit, integer truncation
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Width of a counter that must hold values 0..n-1 (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Fabric-side handshakes plus serial pins of the uart block.
interface uart_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  ena;
  logic                  tx_signal;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  rx_signal;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  // Driven by the fabric / pin environment
  modport master (
    output ena, tx_data, tx_valid, rx_signal, rx_ready,
    input  tx_signal, tx_ready, rx_data, rx_valid
  );

  // Seen by the uart itself
  modport slave (
    input  ena, tx_data, tx_valid, rx_signal, rx_ready,
    output tx_signal, tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/uart_rx.sv
// Serial receiver: 2-flop synchroniser, mid-bit sampling, valid/ready output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ena,
  input  logic                  i_rx,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  localparam int unsigned CNT_W   = cnt_width(CLKS_PER_BIT);
  localparam int unsigned IDX_W   = cnt_width(DATA_WIDTH);
  localparam int unsigned HALF_M1 = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;

  uart_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  w_bit_end;
  logic                  w_half_end;
  logic                  w_last_bit;

  assign w_bit_end  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_half_end = (r_cnt == CNT_W'(HALF_M1));
  assign w_last_bit = (r_idx == IDX_W'(DATA_WIDTH - 1));

  // Bring the asynchronous line into the clk domain; idle level is high
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM plus output handshake; a completing character wins over consumption
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (i_ena && !r_sync2) begin
            r_state <= START;
          end
        end
        START: begin
          if (w_half_end) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_state <= r_sync2 ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[DATA_WIDTH-1:1]};
            if (w_last_bit) begin
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (r_sync2) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/uart_tx.sv
// 8N1-style serial transmitter with its own baud counter.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ena,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int unsigned IDX_W = cnt_width(DATA_WIDTH);

  uart_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_ready;
  logic                  r_tx;
  logic                  w_bit_end;
  logic                  w_last_bit;

  assign w_bit_end  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_idx == IDX_W'(DATA_WIDTH - 1));

  // Frame FSM: accept a character, then drive start, data LSB first, stop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_ready <= 1'b1;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_tx  <= 1'b1;
          if (i_valid && r_ready && i_ena) begin
            r_shift <= i_data;
            r_ready <= 1'b0;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_last_bit) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_tx    = r_tx;

endmodule

// File: rtl/uart.sv
// Full-duplex UART top: independent transmitter and receiver on one baud setting.
module uart
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ
) (
  input  logic clk,
  input  logic reset,
  uart_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

  uart_tx #(
    .DATA_WIDTH   (DATA_WIDTH),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .i_clk   (clk),
    .i_reset (reset),
    .i_ena   (bus.ena),
    .i_data  (bus.tx_data),
    .i_valid (bus.tx_valid),
    .o_ready (bus.tx_ready),
    .o_tx    (bus.tx_signal)
  );

  uart_rx #(
    .DATA_WIDTH   (DATA_WIDTH),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_clk   (clk),
    .i_reset (reset),
    .i_ena   (bus.ena),
    .i_rx    (bus.rx_signal),
    .i_ready (bus.rx_ready),
    .o_data  (bus.rx_data),
    .o_valid (bus.rx_valid)
  );

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart, run at a short bit period to keep the sweep fast.
module tb_uart;
  import uart_pkg::*;

  localparam int unsigned DW       = 8;
  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned CPB      = 10;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic r_loop   = 1'b1;
  logic r_drv_rx = 1'b1;

  int n_vec = 0;
  int n_miss = 0;
  int n_rx = 0;
  logic [DW-1:0] sb[$];

  uart_if #(.DATA_WIDTH(DW)) bus ();

  assign bus.rx_signal = r_loop ? bus.tx_signal : r_drv_rx;

  uart #(
    .DATA_WIDTH (DW),
    .BAUD_RATE  (BAUD),
    .CLK_FREQ   (CLK_FREQ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic wait_tx_ready(input logic lvl, input string tag, input int limit);
    int c = 0;
    while (bus.tx_ready !== lvl && c < limit) begin
      step();
      c++;
    end
    check_val(tag, 32'(bus.tx_ready), 32'(lvl));
  endtask

  task automatic send_tx(input logic [DW-1:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    wait_tx_ready(1'b0, "tx_accept", 100);
    sb.push_back(d);
    bus.tx_valid = 1'b0;
    wait_tx_ready(1'b1, "tx_done", 10000);
  endtask

  task automatic send_serial(input logic [DW-1:0] d, input logic stop_bit);
    logic [DW+1:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int b = 0; b < DW + 2; b++) begin
      r_drv_rx = fr[b];
      wait_cycles(CPB);
    end
    r_drv_rx = 1'b1;
  endtask

  // Consumption monitor: a handshake pending at the falling edge completes on the next rise
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
      n_rx++;
      if (sb.size() == 0) begin
        check_val("rx_unexpected", 32'(bus.rx_data), 32'hFFFF_FFFF);
      end else begin
        check_val("rx_data", 32'(bus.rx_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    int held[10];
    int cyc;
    int ok;
    int hi;
    int rdy;
    int rx_base;

    bus.ena      = 1'b1;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;

    // reset values
    wait_cycles(5);
    check_val("rst_tx_signal", 32'(bus.tx_signal), 32'd1);
    check_val("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check_val("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_val("rst_rx_data", 32'(bus.rx_data), 32'd0);
    reset = 1'b0;
    wait_cycles(3);

    // waveform of 0xA5 on the TX line, looped back into RX
    bus.rx_ready = 1'b1;
    frame = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) held[b] = 0;
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    step();
    check_val("wave_accept", 32'(bus.tx_ready), 32'd0);
    sb.push_back(8'hA5);
    bus.tx_valid = 1'b0;
    cyc = 0;
    while (bus.tx_ready === 1'b0 && cyc < 20000) begin
      if (cyc / CPB < 10 && bus.tx_signal === frame[cyc / CPB]) held[cyc / CPB]++;
      step();
      cyc++;
    end
    for (int b = 0; b < 10; b++) check_val($sformatf("wave_bit%0d", b), 32'(held[b]), CPB);
    check_val("tx_busy_cycles", 32'(cyc), 10 * CPB);
    wait_cycles(5);
    check_val("wave_rx_drained", 32'(sb.size()), 32'd0);

    // back-to-back frames with tx_valid held high
    bus.tx_data  = 8'h11;
    bus.tx_valid = 1'b1;
    wait_tx_ready(1'b0, "b2b_accept", 100);
    sb.push_back(8'h11);
    bus.tx_data = 8'h22;
    wait_tx_ready(1'b1, "b2b_idle", 10000);
    step();
    check_val("b2b_restart", 32'(bus.tx_ready), 32'd0);
    sb.push_back(8'h22);
    bus.tx_valid = 1'b0;
    wait_tx_ready(1'b1, "b2b_done", 10000);
    wait_cycles(5);
    check_val("b2b_drained", 32'(sb.size()), 32'd0);

    // loopback sweep of every character value
    rx_base = n_rx;
    for (int i = 0; i < 256; i++) begin
      send_tx(8'(i));
    end
    wait_cycles(5);
    check_val("sweep_drained", 32'(sb.size()), 32'd0);
    check_val("sweep_count", 32'(n_rx - rx_base), 32'd256);

    // RX holds its character until consumed
    r_loop = 1'b0;
    bus.rx_ready = 1'b0;
    sb.push_back(8'h3C);
    send_serial(8'h3C, 1'b1);
    wait_cycles(2 * CPB);
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      if (bus.rx_valid === 1'b1 && bus.rx_data === 8'h3C) ok++;
      step();
    end
    check_val("rx_hold", 32'(ok), 32'd2000);
    bus.rx_ready = 1'b1;
    step();
    check_val("rx_clear", 32'(bus.rx_valid), 32'd0);
    check_val("rx_hold_drained", 32'(sb.size()), 32'd0);

    // short low glitch is rejected
    r_drv_rx = 1'b0;
    wait_cycles(2);
    r_drv_rx = 1'b1;
    wait_cycles(3 * CPB);
    check_val("glitch_no_valid", 32'(bus.rx_valid), 32'd0);

    // framing error discarded, next good frame received
    send_serial(8'h81, 1'b0);
    wait_cycles(CPB);
    check_val("frame_err_no_valid", 32'(bus.rx_valid), 32'd0);
    sb.push_back(8'h55);
    send_serial(8'h55, 1'b1);
    wait_cycles(2 * CPB);
    check_val("after_err_drained", 32'(sb.size()), 32'd0);

    // enable low: no TX accept, no RX start
    bus.ena      = 1'b0;
    r_loop       = 1'b1;
    bus.tx_data  = 8'h5A;
    bus.tx_valid = 1'b1;
    hi  = 0;
    rdy = 0;
    for (int c = 0; c < 5 * CPB; c++) begin
      if (bus.tx_signal === 1'b1) hi++;
      if (bus.tx_ready === 1'b1) rdy++;
      step();
    end
    bus.tx_valid = 1'b0;
    check_val("ena0_tx_idle", 32'(hi), 5 * CPB);
    check_val("ena0_tx_ready", 32'(rdy), 5 * CPB);
    r_loop = 1'b0;
    send_serial(8'h12, 1'b1);
    wait_cycles(2 * CPB);
    check_val("ena0_rx_no_valid", 32'(bus.rx_valid), 32'd0);
    bus.ena = 1'b1;
    wait_cycles(2);

    // reset mid-frame aborts both sides
    r_loop       = 1'b1;
    bus.tx_data  = 8'hF0;
    bus.tx_valid = 1'b1;
    wait_tx_ready(1'b0, "rst_mid_accept", 100);
    bus.tx_valid = 1'b0;
    wait_cycles(4 * CPB);
    reset = 1'b1;
    step();
    check_val("rst_mid_tx_signal", 32'(bus.tx_signal), 32'd1);
    check_val("rst_mid_tx_ready", 32'(bus.tx_ready), 32'd1);
    check_val("rst_mid_rx_valid", 32'(bus.rx_valid), 32'd0);
    reset = 1'b0;
    wait_cycles(12 * CPB);
    check_val("rst_mid_no_rx", 32'(bus.rx_valid), 32'd0);
    check_val("rst_mid_line_idle", 32'(bus.tx_signal), 32'd1);
    check_val("final_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
